// File: rtl/pbit_local_field.sv
// Beta-scaled local field for one p-bit: serial +/-J accumulation, bias, beta multiply, symmetric saturation.
// Optional macro PBIT_BIAS_EN adds the signed bias port; without it the accumulator starts at zero.
module pbit_local_field #(
  parameter int N         = 16,
  parameter int W_BITS    = 8,
  parameter int BETA_BITS = 8,
  parameter int BETA_FRAC = 4,
  parameter int PHASE_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N-1:0]              spins,
`ifdef PBIT_BIAS_EN
  input  logic signed [W_BITS-1:0]  bias,
`endif
  input  logic [BETA_BITS-1:0]      beta,
  output logic [$clog2(N)-1:0]      weight_addr,
  input  logic signed [W_BITS-1:0]  weight_data,
  output logic signed [PHASE_W-1:0] phase,
  output logic                      phase_valid,
  output logic                      busy
);

  localparam int AW     = $clog2(N);
  localparam int ACC_W  = W_BITS + $clog2(N + 1) + 1;
  localparam int PROD_W = ACC_W + BETA_BITS + 1;

  // Symmetric clamp: the tanh core negates its operand, so the most negative code is excluded.
  localparam logic signed [PROD_W-1:0] P_MAX =
    {{(PROD_W - PHASE_W + 1){1'b0}}, {(PHASE_W - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] P_MIN = -P_MAX;
  localparam logic signed [PHASE_W-1:0] PH_MAX = {1'b0, {(PHASE_W - 1){1'b1}}};
  localparam logic signed [PHASE_W-1:0] PH_MIN = -PH_MAX;

  typedef enum logic [2:0] {IDLE, FETCH, ACC, SCALE, SAT} state_t;

  state_t                      state_q;
  logic [N-1:0]                spins_q;
  logic [BETA_BITS-1:0]        beta_q;
  logic signed [ACC_W-1:0]     acc_q, acc_d, acc_init, w_ext;
  logic signed [PROD_W-1:0]    prod_q, prod_d, t;
  logic [AW-1:0]               addr_q, cnt_q;
  logic signed [PHASE_W-1:0]   phase_q, phase_d;
  logic                        valid_q, busy_q;

  always_comb begin
`ifdef PBIT_BIAS_EN
    acc_init = {{(ACC_W - W_BITS){bias[W_BITS-1]}}, bias};
`else
    acc_init = '0;
`endif
    w_ext  = {{(ACC_W - W_BITS){weight_data[W_BITS-1]}}, weight_data};
    acc_d  = spins_q[cnt_q] ? acc_q + w_ext : acc_q - w_ext;
    prod_d = $signed({{(PROD_W - ACC_W){acc_q[ACC_W-1]}}, acc_q}) *
             $signed({{(PROD_W - BETA_BITS){1'b0}}, beta_q});
    t      = prod_q >>> BETA_FRAC;
    if (t > P_MAX)      phase_d = PH_MAX;
    else if (t < P_MIN) phase_d = PH_MIN;
    else                phase_d = t[PHASE_W-1:0];
  end

  // NOTE: every register here is state, so all assignments are non-blocking; the
  // datapath registers are reset too so an aborted computation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      spins_q <= '0;
      beta_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          spins_q <= spins;
          beta_q  <= beta;
          acc_q   <= acc_init;
          addr_q  <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          addr_q  <= AW'(1);
          state_q <= ACC;
        end
        ACC: begin
          // weight_data here is J[cnt_q], requested two edges earlier.
          acc_q <= acc_d;
          cnt_q <= cnt_q + AW'(1);
          if (addr_q != AW'(N - 1)) addr_q <= addr_q + AW'(1);
          if (cnt_q == AW'(N - 1))  state_q <= SCALE;
        end
        SCALE: begin
          prod_q  <= prod_d;
          state_q <= SAT;
        end
        SAT: begin
          phase_q <= phase_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weight_addr = addr_q;
  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pbit_local_field.sv
// Scoreboard bench for pbit_local_field at N=4 with a synchronous-read weight memory model.
// Expected phase and completion cycle are queued at each accepted start and checked on phase_valid.
module tb_pbit_local_field;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [N-1:0]      spins = '0;
  logic signed [7:0] bias = '0;
  logic [7:0]        beta = '0;
  logic [1:0]        weight_addr;
  logic signed [7:0] weight_data = '0;
  logic signed [7:0] phase;
  logic              phase_valid;
  logic              busy;

  logic signed [7:0] mem [N];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct { int ph; int cyc; } exp_t;
  exp_t sb[$];

  pbit_local_field #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spins(spins),
`ifdef PBIT_BIAS_EN
    .bias(bias),
`endif
    .beta(beta), .weight_addr(weight_addr), .weight_data(weight_data),
    .phase(phase), .phase_valid(phase_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) weight_data <= mem[weight_addr];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model(input logic [N-1:0] sp, input int b, input int bt);
    int acc, t;
`ifdef PBIT_BIAS_EN
    acc = b;
`else
    acc = 0;
`endif
    for (int j = 0; j < N; j++) acc += sp[j] ? int'(mem[j]) : -int'(mem[j]);
    t = (acc * bt) >>> 4;
    if (t > 127) t = 127;
    if (t < -127) t = -127;
    return t;
  endfunction

  always @(negedge clk) begin
    if (phase_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("phase", int'(phase), e.ph);
        check("latency", cyc, e.cyc);
        check("busy_at_valid", int'(busy), 0);
      end
    end
  end

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [N-1:0] sp, input int b, input int bt);
    exp_t e;
    spins = sp; bias = 8'(b); beta = 8'(bt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.ph = model(sp, b, bt);
    e.cyc = cyc + N + 3;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [N-1:0] sp, input int b, input int bt);
    @(negedge clk);
    start_op(sp, b, bt);
    wait_done();
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    mem[0] = 8'(a); mem[1] = 8'(b); mem[2] = 8'(c); mem[3] = 8'(d);
  endtask

  initial begin
    set_w(10, -3, 5, 7);
    repeat (3) @(negedge clk);
    check("rst_phase", int'(phase), 0);
    check("rst_valid", int'(phase_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_addr", int'(weight_addr), 0);
    rst_n = 1'b1;

    // Basic op with busy window and address sequence.
    @(negedge clk);
    start_op(4'b1011, 2, 8'h10);
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      check("busy_high", int'(busy), 1);
      if (i < N) check("addr", int'(weight_addr), i);
    end
    @(negedge clk);
    check("busy_low", int'(busy), 0);
    wait_done();

    run_op(4'b1011, 2, 8'h08);
    run_op(4'b1011, -20, 8'h08);

    set_w(127, 127, 127, 127);
    run_op(4'b1111, 127, 8'h20);
    run_op(4'b0000, -128, 8'h20);
    check("no_minus_128", int'(phase == -8'sd128), 0);

    // Start while busy is ignored; start during the valid cycle is accepted.
    set_w(10, -3, 5, 7);
    @(negedge clk);
    start_op(4'b1011, 2, 8'h10);
    repeat (3) @(negedge clk);
    spins = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!phase_valid && n < 20) begin @(negedge clk); n++; end
      check("valid_seen", int'(phase_valid), 1);
    end
    start_op(4'b0110, -5, 8'h18);
    wait_done();

    // Reset mid-operation aborts with no pulse.
    @(negedge clk);
    start_op(4'b1011, 2, 8'h10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(phase_valid), 0);
    check("mid_rst_phase", int'(phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_op(4'b1011, 2, 8'h10);

    run_op(4'b1011, 2, 8'h00);
    check("beta0_phase", int'(phase), 0);

    for (int r = 0; r < 4; r++) begin
      set_w($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
      run_op(4'($urandom), int'($urandom_range(255)) - 128, $urandom_range(255));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
